// File: rtl/div_radix2.sv
// div_radix2: multi-cycle restoring radix-2 integer divider, one quotient bit
// per cycle, start/ready handshake with annul (flush) support.
// Optional build macro: DIV_EARLY_EXIT_EN -- when defined, operations whose
// dividend magnitude is below the divisor magnitude skip the iteration loop.
module div_radix2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    r_rem;       // partial remainder
  logic [DATA_W-1:0]    r_quo;       // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0]    r_divisor;   // divisor magnitude
  logic                 r_quo_neg;
  logic                 r_rem_neg;
`ifdef DIV_EARLY_EXIT_EN
  logic                 r_early;
`endif

  // Operand magnitudes and sign flags at capture time
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [DATA_W-1:0]    w_abs1;
  logic [DATA_W-1:0]    w_abs2;

  assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign w_abs1    = w_op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
  assign w_abs2    = w_op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
  logic                 w_early;
  assign w_early = (w_abs1 < w_abs2);
`endif

  // One shift-subtract step on the 2W+1-bit {rem, quo} working value
  logic [DATA_W:0]      w_rem_hi;
  logic                 w_ge;
  logic [DATA_W-1:0]    w_diff;
  logic [DATA_W-1:0]    w_rem_nxt;
  logic [DATA_W-1:0]    w_quo_nxt;

  assign w_rem_hi  = {r_rem, r_quo[DATA_W-1]};
  assign w_ge      = (w_rem_hi >= {1'b0, r_divisor});
  // True difference is below the divisor, so the low W bits are exact
  assign w_diff    = w_rem_hi[DATA_W-1:0] - r_divisor;
  assign w_rem_nxt = w_ge ? w_diff : w_rem_hi[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};

  // Sign correction of the final step and of the dividend (by-zero / early path)
  logic [DATA_W-1:0]    w_quo_res;
  logic [DATA_W-1:0]    w_rem_res;
  logic [DATA_W-1:0]    w_dvd_res;

  assign w_quo_res = r_quo_neg ? (~w_quo_nxt + DATA_W'(1)) : w_quo_nxt;
  assign w_rem_res = r_rem_neg ? (~w_rem_nxt + DATA_W'(1)) : w_rem_nxt;
  assign w_dvd_res = r_rem_neg ? (~r_quo + DATA_W'(1)) : r_quo;

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_quo_neg <= 1'b0;
      r_rem_neg <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      r_early   <= 1'b0;
`endif
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_quo_neg <= w_op1_neg ^ w_op2_neg;
            r_rem_neg <= w_op1_neg;
            r_cnt     <= '0;
`ifdef DIV_EARLY_EXIT_EN
            r_early   <= 1'b0;
`endif
            if (opdata2_i == '0) begin
              r_state <= S_BY_ZERO;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (w_early) begin
              r_state <= S_BY_ZERO;
              r_early <= 1'b1;
            end
`endif
            else begin
              r_state <= S_ON;
            end
          end
        end

        S_BY_ZERO: begin
          // Quotient all ones for /0 (zero on early exit); remainder = dividend
`ifdef DIV_EARLY_EXIT_EN
          result_o <= {w_dvd_res, {DATA_W{~r_early}}};
`else
          result_o <= {w_dvd_res, {DATA_W{1'b1}}};
`endif
          ready_o  <= 1'b1;
          r_state  <= S_END;
        end

        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              result_o <= {w_rem_res, w_quo_res};
              ready_o  <= 1'b1;
              r_state  <= S_END;
            end
          end
        end

        S_END: begin
          ready_o <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          ready_o <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases plus randomized divides
// compared against a plain-arithmetic reference model.
module tb_div_radix2;

  logic        clk;
  logic        rst_n;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          checks;
  int          errors;
  logic [63:0] last_exp;

  div_radix2 #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from ordinary integer division
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference: cycles from acceptance to ready_o
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn);
    longint ma, mb;
    if (b == 32'd0) return 2;
    ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 2;
`endif
    return 33;
  endfunction

  // Issue one divide; lat = cycle index of ready_o (99 if it never came)
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output logic [63:0] res);
    bit seen;
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    lat  = 0;
    res  = '0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o === 1'b1) begin
        seen = 1'b1;
        res  = result_o;
      end else if (lat == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    if (!seen) lat = 99;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", ready_o);
    end
    checks++;
    if (result_o !== 64'd0) begin
      errors++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 64'd0;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res;
    do_div(32'd100, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL u100_7_lat: got %0d want 33", lat); end
    checks++;
    if (res !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL u100_7_res: got %h want 000000020000000e", res);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL u100_7_pulse: got %b want 0", ready_o); end
    checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL u100_7_hold: got %h want 000000020000000e", result_o);
    end
    last_exp = 64'h00000002_0000000E;
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
    checks++;
    if (lat != 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL s_m7_2: got %h lat %0d want fffffffffffffffd lat 33", res, lat);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
    checks++;
    if (res !== 64'h00000000_80000000) begin
      errors++; $display("FAIL s_overflow: got %h want 0000000080000000", res);
    end
    last_exp = 64'h00000000_80000000;
  endtask

  task automatic test_by_zero();
    int lat; logic [63:0] res;
    do_div(32'd5, 32'd0, 1'b0, lat, res);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL dz_lat: got %0d want 2", lat); end
    checks++;
    if (res !== 64'h00000005_FFFFFFFF) begin
      errors++; $display("FAIL dz_res: got %h want 00000005ffffffff", res);
    end
    do_div(32'hFFFF_FFF9, 32'd0, 1'b1, lat, res);
    checks++;
    if (lat != 2 || res !== 64'hFFFFFFF9_FFFFFFFF) begin
      errors++; $display("FAIL dz_signed: got %h lat %0d want fffffff9ffffffff lat 2", res, lat);
    end
    do_div(32'd21, 32'd4, 1'b0, lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000001_00000005) begin
      errors++; $display("FAIL dz_after: got %h lat %0d want 0000000100000005 lat 33", res, lat);
    end
    last_exp = 64'h00000001_00000005;
  endtask

  task automatic test_annul();
    int lat, pulses; logic [63:0] res;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL annul_ready: got %0d pulses want 0", pulses); end
    checks++;
    if (result_o !== last_exp) begin
      errors++; $display("FAIL annul_hold: got %h want %h", result_o, last_exp);
    end
    do_div(32'd9, 32'd3, 1'b0, lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000003) begin
      errors++; $display("FAIL annul_next: got %h lat %0d want 0000000000000003 lat 33", res, lat);
    end
    last_exp = 64'h00000000_00000003;
  endtask

  task automatic test_midreset();
    int pulses;
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL midreset_async: got ready %b result %h want 0 0", ready_o, result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || result_o !== 64'd0) begin
      errors++; $display("FAIL midreset_after: got %0d pulses result %h want 0 0", pulses, result_o);
    end
    last_exp = 64'd0;
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res;
    do_div(32'd20, 32'd6, 1'b0, lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000002_00000003) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d want 0000000200000003 lat 33", res, lat);
    end
    do_div(32'd20, 32'hFFFF_FFFA, 1'b1, lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000002_FFFFFFFD) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d want 00000002fffffffd lat 33", res, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b want 0", ready_o); end
    last_exp = 64'h00000002_FFFFFFFD;
  endtask

  task automatic test_early_exit();
    int lat, el; logic [63:0] res;
`ifdef DIV_EARLY_EXIT_EN
    el = 2;
`else
    el = 33;
`endif
    do_div(32'd3, 32'd10, 1'b0, lat, res);
    checks++;
    if (lat != el || res !== 64'h00000003_00000000) begin
      errors++; $display("FAIL early_3_10: got %h lat %0d want 0000000300000000 lat %0d", res, lat, el);
    end
    do_div(32'hFFFF_FFFD, 32'd10, 1'b1, lat, res);
    checks++;
    if (lat != el || res !== 64'hFFFFFFFD_00000000) begin
      errors++; $display("FAIL early_m3_10: got %h lat %0d want fffffffd00000000 lat %0d", res, lat, el);
    end
    do_div(32'd0, 32'd5, 1'b0, lat, res);
    checks++;
    if (lat != el || res !== 64'd0) begin
      errors++; $display("FAIL early_zero: got %h lat %0d want 0 lat %0d", res, lat, el);
    end
    do_div(32'd10, 32'd10, 1'b0, lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000001) begin
      errors++; $display("FAIL early_equal: got %h lat %0d want 0000000000000001 lat 33", res, lat);
    end
    last_exp = 64'h00000000_00000001;
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] res, exp;
    logic [31:0] a, b;
    logic sgn;
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 3));
        1:       b = $urandom;
        2:       b = 32'($urandom_range(1, 1000)) ^ (sgn && $urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'd0);
        default: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 100)); end
      endcase
      exp = ref_div(a, b, sgn);
      do_div(a, b, sgn, lat, res);
      checks++;
      if (res !== exp || lat != ref_lat(a, b, sgn)) begin
        errors++;
        $display("FAIL rand_%0d: %h/%h s=%b got %h lat %0d want %h lat %0d",
                 n, a, b, sgn, res, lat, exp, ref_lat(a, b, sgn));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_by_zero();
    test_annul();
    test_midreset();
    test_back_to_back();
    test_early_exit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Multi-cycle 32-bit integer divider core: the responder side of the start/ready divide handshake driven by the execute-stage divide controller.
- Accepts signed or unsigned operands on start_i and runs restoring radix-2 shift-subtract, one quotient bit per cycle.
- Returns {remainder, quotient} on result_o with a one-cycle ready_o pulse; the controller holds the pipeline stall until that pulse.
- annul_i aborts an in-flight divide on pipeline flush.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W; iteration count = DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- signed_div_i  input  1  1 = signed (two's complement) divide; sampled with start_i.
- opdata1_i  input  DATA_W  dividend; sampled with start_i.
- opdata2_i  input  DATA_W  divisor; sampled with start_i.
- start_i  input  1  divide request, level; the controller holds it high until it sees ready_o.
- annul_i  input  1  abort the current operation.
- result_o  output  2*DATA_W  [2W-1:W] = remainder, [W-1:0] = quotient; registered.
- ready_o  output  1  result valid; high for exactly one cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready_o=0, result_o=0, counter=0, working registers 0. Reset mid-operation abandons it; no ready_o pulse.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0: capture operands and signed_div_i.
  - Divisor == 0: go to BY_ZERO.
  - Otherwise: go to ON, counter=0.
  - start_i with annul_i=1 is ignored; stay IDLE.
- Operand capture:
  - If signed, both operands are replaced by their absolute values.
  - Quotient-negate flag = sign(op1) XOR sign(op2).
  - Remainder-negate flag = sign(op1).
  - Unsigned: both flags 0.
- ON:
  - Each cycle: 2W+1-bit working reg {rem,quo} shifts left 1; if rem_hi >= |divisor|, subtract and set quo LSB=1.
  - counter increments; after DATA_W iterations go to END.
  - annul_i=1 in any ON cycle: go to IDLE immediately; no ready_o, result_o unchanged.
- BY_ZERO: go to END with quotient = all ones, remainder = raw dividend (unsigned or signed identical).
- END:
  - ready_o=1 for one cycle; result_o loaded with sign-corrected quotient/remainder on END entry.
  - Unconditional return to IDLE next cycle, regardless of start_i or annul_i.
- Latency: start accepted in cycle 0 -> ON cycles 1..32 -> END/ready_o in cycle 33. Divide-by-zero: ready_o in cycle 2.
- result_o holds its last value until the next END; valid whenever ready_o=1.
- start_i is ignored outside IDLE. Operand changes after capture have no effect.
- Because ready_o is one cycle and END always returns to IDLE, a back-to-back divide re-asserting start_i in the cycle after ready_o is accepted normally.
- Signed overflow 0x80000000 / -1 (0xFFFFFFFF): quotient 0x80000000, remainder 0, no exception; falls out of the magnitude path.

Optional Feature:
- DIV_EARLY_EXIT_EN defined:
  - In IDLE, if divisor != 0 and |dividend| < |divisor| (unsigned compare after abs), skip ON and go straight to END.
  - Result: quotient 0, remainder = original dividend; ready_o in cycle 2.
  - Dividend 0 also takes this path.
- Not defined: all nonzero-divisor operations take the full 33-cycle latency; the compare logic is absent.

Test Plan:
- Unsigned 100 / 7 (start cycle 0) -> ready_o=1 only in cycle 33, result_o=64'h00000002_0000000E.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000.
- Divide-by-zero 5 / 0 -> ready_o in cycle 2, result_o=64'h00000005_FFFFFFFF; then state IDLE.
- annul_i pulsed in cycle 10 of 100/7 -> no ready_o within 40 cycles, result_o unchanged; new start 9/3 next cycle -> 64'h00000000_00000003 at cycle 33 relative.
- rst_n low for 1 cycle mid-ON -> ready_o=0, result_o=0 immediately (async); back-to-back 20/6 then 20/-6 signed with start re-asserted the cycle after ready_o -> 64'h00000002_00000003 then 64'h00000002_FFFFFFFD, each exactly one ready_o pulse.
- With DIV_EARLY_EXIT_EN: 3 / 10 unsigned -> ready_o in cycle 2, result_o=64'h00000003_00000000; without the macro -> same value in cycle 33.
